// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard, SYSCALL pause/halt and performance-counter control
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic        ex_MemToReg,
  input  logic        ex_RegWrite,
  input  logic [4:0]  ex_W_num,
  input  logic        ex_branch_taken,
  input  logic        mem_SYSCALL,
  input  logic [31:0] mem_v0,
  input  logic        go,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        idex_hold,
  output logic        exmem_hold,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic        halted,
  output logic        paused,
  output logic [31:0] cycle_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  localparam logic [1:0] RUN = 2'd0, PAUSE = 2'd1, RESUME = 2'd2, HALT = 2'd3;
  logic [1:0] state, state_nx;
  logic       go_q, sys, frozen, hold_all, load_use, br, lu;
  // Hazard detection; SYSCALL is only seen in RUN so the stalled one advances once in RESUME
  always_comb begin
    load_use = ex_MemToReg & ex_RegWrite & (ex_W_num != 5'd0) &
               ((id_rs_used & (id_rs == ex_W_num)) | (id_rt_used & (id_rt == ex_W_num)));
    sys      = (state == RUN) & mem_SYSCALL;
    frozen   = (state == PAUSE) | (state == HALT);
    hold_all = sys | frozen;
    br       = ex_branch_taken & ~hold_all;
    lu       = load_use & ~hold_all & ~ex_branch_taken;
    pc_hold     = hold_all | lu;
    ifid_hold   = hold_all | lu;
    idex_hold   = hold_all;
    exmem_hold  = hold_all;
    ifid_flush  = br;
    idex_flush  = br | lu;
    memwb_flush = hold_all;
    halted      = state == HALT;
    paused      = state == PAUSE;
  end
  // Next state: SYSCALL value picks halt vs pause; resume needs a fresh go edge
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     state_nx = sys ? ((mem_v0 == 32'd10) ? HALT : PAUSE) : RUN;
      PAUSE:   state_nx = (go & ~go_q) ? RESUME : PAUSE;
      RESUME:  state_nx = RUN;
      default: state_nx = HALT;
    endcase
  end
  // State, go edge history and wrapping performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      go_q      <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      go_q      <= go;
      cycle_cnt <= cycle_cnt + {31'd0, ~frozen};
      stall_cnt <= stall_cnt + {31'd0, lu};
      flush_cnt <= flush_cnt + {31'd0, br};
    end
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset (0 = reset, applied immediately, independent of clk).
REQ-003 SHALL have: id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have: id_rs_used, id_rt_used  in  1 each  ID instruction reads rs / rt.
REQ-005 SHALL have: ex_MemToReg, ex_RegWrite  in  1 each  control of the EX instruction; ex_W_num  in  5  its destination register.
REQ-006 SHALL have: ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-007 SHALL have: mem_SYSCALL  in  1  SYSCALL in MEM; mem_v0  in  32  $v0 value accompanying it.
REQ-008 SHALL have: go  in  1  level resume request, active on rising edge.
REQ-009 SHALL have hold outputs (1 = register keeps value, hold beats flush at the register): pc_hold, ifid_hold, idex_hold, exmem_hold, each 1 bit.
REQ-010 SHALL have flush outputs (1 = register loads zeros): ifid_flush, idex_flush, memwb_flush, each 1 bit.
REQ-011 SHALL have status outputs: halted, paused (1 bit each); cycle_cnt, stall_cnt, flush_cnt (32 bits each).

Function
REQ-012 SHALL implement states RUN, PAUSE, RESUME, HALT; hold/flush outputs combinational from state and inputs; counters and state registered.
REQ-013 load_use SHALL = ex_MemToReg & ex_RegWrite & (ex_W_num != 0) & ((id_rs_used & id_rs == ex_W_num) | (id_rt_used & id_rt == ex_W_num)).
REQ-014 sys SHALL = mem_SYSCALL in RUN only; sys_halt = sys & (mem_v0 == 32'd10); sys_pause = sys & (mem_v0 != 32'd10).
REQ-015 RUN priority SHALL be sys > ex_branch_taken > load_use > normal.
REQ-016 sys (any) SHALL assert pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_flush; all other flushes 0.
REQ-017 Branch (no sys) SHALL assert ifid_flush, idex_flush only; load_use in the same cycle SHALL be ignored.
REQ-018 load_use (no sys, no branch) SHALL assert pc_hold, ifid_hold, idex_flush only.
REQ-019 Normal SHALL drive all hold/flush outputs 0.
REQ-020 Transitions: RUN->HALT on sys_halt; RUN->PAUSE on sys_pause; PAUSE->RESUME on go rising edge (go=1, go_q=0); RESUME->RUN unconditionally; HALT absorbing until reset.
REQ-021 PAUSE and HALT SHALL drive the same outputs as REQ-016 every cycle.
REQ-022 RESUME SHALL ignore mem_SYSCALL (stalled SYSCALL advances exactly once) and apply REQ-017/018/019 normally.
REQ-023 go_q SHALL register go every cycle in all states; go held high on PAUSE entry SHALL NOT resume until it falls and rises again.
REQ-024 cycle_cnt SHALL increment in RUN and RESUME; frozen in PAUSE and HALT.
REQ-025 stall_cnt SHALL increment on each load_use-stall cycle per REQ-018; flush_cnt on each branch-flush cycle per REQ-017.
REQ-026 Counters SHALL wrap 32'hFFFFFFFF -> 0 without flag.
REQ-027 halted SHALL = (state == HALT); paused SHALL = (state == PAUSE).

Reset
REQ-028 rst=0 SHALL immediately force state RUN, go_q=0, all counters 0, halted=0, paused=0.
REQ-029 Reset asserted in any state mid-operation SHALL abort it with no residual effect; first rising edge after rst=1 is a normal RUN cycle.

Verification
REQ-030 Load-use: ex_MemToReg=1, ex_RegWrite=1, ex_W_num=8, id_rs=8, id_rs_used=1 -> pc_hold=1, ifid_hold=1, idex_flush=1, stall_cnt +1; repeat with ex_W_num=0 -> no stall.
REQ-031 Branch + load_use same cycle -> ifid_flush=1, idex_flush=1, pc_hold=0, flush_cnt +1, stall_cnt unchanged.
REQ-032 mem_SYSCALL=1, mem_v0=10 -> same cycle all holds=1, memwb_flush=1; next cycle halted=1; go pulses no effect; cycle_cnt frozen until rst=0.
REQ-033 mem_SYSCALL=1, mem_v0=1, go already high -> PAUSE; go stays high: remains paused; go 0 then 1 -> RESUME one cycle with mem_SYSCALL still 1 and all holds 0, then RUN.
REQ-034 SYSCALL in MEM with ex_branch_taken=1 -> holds only, flush_cnt unchanged; after resume, branch flush in RESUME cycle, flush_cnt +1.
REQ-035 Preload cycle_cnt to 32'hFFFFFFFF via long run or force -> next RUN cycle reads 0; rst=0 mid-PAUSE -> paused=0 immediately, counters 0.
